// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and sizes for the 8-way round-robin mux scheduler.
package mux8_rr_scheduler_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// Requester-side bus of the scheduler: requests and data in, select/grant/data out.
interface mux8_rr_scheduler_if;
  import mux8_rr_scheduler_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic             dout;

  modport master (
    output req, din,
    input  sel, gnt, gnt_valid, dout
  );

  modport slave (
    input  req, din,
    output sel, gnt, gnt_valid, dout
  );

endinterface

// File: rtl/mux8_rr_scheduler_mux.sv
// Plain 8:1 single-bit mux used as the shared output channel datapath.
module mux_8_to_1 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler owning the select of an 8:1 mux, with bounded hold and handover gap.
//
// state | meaning
// IDLE  | no grant, arbitrating every edge
// GRANT | sel/gnt owned by one requester, hold counter running
// GAP   | dead cycles after a release, sel keeps last winner
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux8_rr_scheduler_if.slave   bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       gap_q, gap_d;

  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] arb_base;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             release_now;
  logic             mux_y;

  function automatic logic [SEL_W-1:0] pick(input logic [SEL_W-1:0] base,
                                            input logic [N_REQ-1:0] r);
    logic [SEL_W-1:0] idx;
    pick = base;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = base + SEL_W'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gap_d       = gap_q;

    any_req     = |bus.req;
    next_ptr    = sel_q + 3'd1;
    release_now = !bus.req[sel_q] || (hold_q == HOLD_LAST);
    // A back-to-back regrant searches from the releasing winner's successor.
    arb_base    = (state_q == GRANT) ? next_ptr : ptr_q;
    win         = pick(arb_base, bus.req);

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          sel_d       = win;
          gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_d = hold_q + 8'd1;
        end else begin
          ptr_d = next_ptr;
          if (GAP_CYCLES > 0) begin
            state_d     = GAP;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gap_d       = '0;
          end else if (any_req) begin
            sel_d       = win;
            gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gnt_valid_d = 1'b1;
            hold_d      = '0;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end
      GAP: begin
        // The last gap edge arbitrates directly so the gap is exactly GAP_CYCLES long.
        if (gap_q == GAP_LAST) begin
          if (any_req) begin
            state_d     = GRANT;
            sel_d       = win;
            gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gnt_valid_d = 1'b1;
            hold_d      = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
    end
  end

  mux_8_to_1 u_mux (
    .d (bus.din),
    .s (sel_q),
    .y (mux_y)
  );

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.dout      = gnt_valid_q & mux_y;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Scoreboard bench: directed steps push expected outputs, a monitor pops and compares each cycle.
module tb_mux8_rr_scheduler;
  import mux8_rr_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  mux8_rr_scheduler_if bus_a ();
  mux8_rr_scheduler_if bus_b ();

  mux8_rr_scheduler #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  mux8_rr_scheduler #(.MAX_HOLD(2), .GAP_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  typedef struct {
    int         dut;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       dout;
    int         tag;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_steps = 0;

  function automatic string tag_name(input int t);
    case (t)
      0:       return "reset";
      1:       return "full_load";
      2:       return "single";
      3:       return "early_rel";
      4:       return "mid_reset";
      5:       return "b2b_wrap";
      default: return "other";
    endcase
  endfunction

  task automatic step(input int d, input logic rst, input logic [7:0] r,
                      input logic [7:0] di, input logic [2:0] es,
                      input logic [7:0] eg, input int tag);
    exp_t e;
    @(posedge clk);
    #2;
    if (d == 0) begin
      rst_a_n   = rst;
      bus_a.req = r;
      bus_a.din = di;
    end else begin
      rst_b_n   = rst;
      bus_b.req = r;
      bus_b.din = di;
    end
    e.dut  = d;
    e.sel  = es;
    e.gnt  = eg;
    e.dout = (eg != 8'h00) ? di[es] : 1'b0;
    e.tag  = tag;
    e.idx  = n_steps;
    n_steps++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [2:0] a_sel;
    logic [7:0] a_gnt;
    logic       a_gv;
    logic       a_dout;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          a_sel = bus_a.sel; a_gnt = bus_a.gnt; a_gv = bus_a.gnt_valid; a_dout = bus_a.dout;
        end else begin
          a_sel = bus_b.sel; a_gnt = bus_b.gnt; a_gv = bus_b.gnt_valid; a_dout = bus_b.dout;
        end
        total++;
        if (a_sel !== e.sel || a_gnt !== e.gnt || a_gv !== (e.gnt != 8'h00) || a_dout !== e.dout) begin
          bad++;
          $display("FAIL %s step %0d: got sel=%0d gnt=%h gv=%b dout=%b, want sel=%0d gnt=%h gv=%b dout=%b",
                   tag_name(e.tag), e.idx, a_sel, a_gnt, a_gv, a_dout,
                   e.sel, e.gnt, (e.gnt != 8'h00), e.dout);
        end
      end
    end
  end

  initial begin : stimulus
    rst_a_n   = 1'b0;
    rst_b_n   = 1'b0;
    bus_a.req = '0;
    bus_a.din = '0;
    bus_b.req = '0;
    bus_b.din = '0;

    // reset with all requesters asserted
    repeat (2) step(0, 1'b0, 8'hFF, 8'hA5, 3'd0, 8'h00, 0);

    // full load: 4 grant cycles + 1 gap per requester, wrapping 7 -> 0
    for (int i = 0; i < 8; i++) begin
      repeat (4) step(0, 1'b1, 8'hFF, 8'hA5, 3'(i), 8'(1 << i), 1);
      step(0, 1'b1, 8'hFF, 8'hA5, 3'(i), 8'h00, 1);
    end
    step(0, 1'b1, 8'hFF, 8'hA5, 3'd0, 8'h01, 1);

    // sole requester 5
    step(0, 1'b0, 8'h00, 8'h20, 3'd0, 8'h00, 2);
    repeat (4) step(0, 1'b1, 8'h20, 8'h20, 3'd5, 8'h20, 2);
    step(0, 1'b1, 8'h20, 8'h20, 3'd5, 8'h00, 2);
    repeat (2) step(0, 1'b1, 8'h20, 8'h20, 3'd5, 8'h20, 2);

    // early release of requester 3, then 4 wins before 3
    step(0, 1'b0, 8'h00, 8'h08, 3'd0, 8'h00, 3);
    repeat (2) step(0, 1'b1, 8'h08, 8'h08, 3'd3, 8'h08, 3);
    step(0, 1'b1, 8'h00, 8'h08, 3'd3, 8'h00, 3);
    repeat (4) step(0, 1'b1, 8'h18, 8'h08, 3'd4, 8'h10, 3);
    step(0, 1'b1, 8'h18, 8'h08, 3'd4, 8'h00, 3);
    step(0, 1'b1, 8'h18, 8'h08, 3'd3, 8'h08, 3);

    // reset during grant to 2; pointer must restart at 0
    step(0, 1'b0, 8'h00, 8'h04, 3'd0, 8'h00, 4);
    repeat (2) step(0, 1'b1, 8'h04, 8'h04, 3'd2, 8'h04, 4);
    step(0, 1'b0, 8'hFF, 8'h04, 3'd0, 8'h00, 4);
    step(0, 1'b1, 8'hFF, 8'h04, 3'd0, 8'h01, 4);

    // no gap, hold 2: 7 -> 0 -> 6 -> 0 back to back, then idle
    step(1, 1'b0, 8'h00, 8'h81, 3'd0, 8'h00, 5);
    repeat (2) step(1, 1'b1, 8'h80, 8'h81, 3'd7, 8'h80, 5);
    repeat (2) step(1, 1'b1, 8'h41, 8'h81, 3'd0, 8'h01, 5);
    repeat (2) step(1, 1'b1, 8'h41, 8'h81, 3'd6, 8'h40, 5);
    step(1, 1'b1, 8'h41, 8'h81, 3'd0, 8'h01, 5);
    repeat (2) step(1, 1'b1, 8'h00, 8'h81, 3'd0, 8'h00, 5);

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
